out_port_arbiter: RTL and testbench
===================================

# out_port_arbiter

Shares the single host serial output channel between up to NREQ output devices: the numeric display, the character terminal and debug tracers. Each device presents byte packets on a valid/ready port. The arbiter grants one device at a time in round-robin order and holds the grant until that device's packet ends. It sits between the output-device modules and the serial transmit shim, so device output on the host side never interleaves mid-line.

## Interface
- NREQ, 4: number of requester ports, 2..8
- TIMEOUT, 255: stall cycles before a forced release; used only with OUT_ARB_TIMEOUT_EN; 1..65535
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NREQ  per-requester byte valid
- req_data  in  NREQ*8  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  NREQ  byte is the last byte of the packet (e.g. the '\n')
- req_ready  out  NREQ  byte accepted from requester i
- snd_valid  out  1  byte valid towards the serial shim
- snd_data  out  8  byte
- snd_last  out  1  end-of-packet marker
- snd_ready  in  1  shim accepts the byte
- grant  out  $clog2(NREQ)  index of the current or most recent holder
- busy  out  1  high in the GRANT state
- timeout_err  out  1  sticky: a forced release has occurred

## Operation
- FSM states: IDLE, GRANT.
- IDLE:
  - Search req_valid for the first set bit, starting at ptr and wrapping modulo NREQ.
  - If a bit is found, register its index in grant and go to GRANT.
  - If none is set, stay in IDLE.
- GRANT, pure combinational pass-through from requester g=grant to the shim:
  - snd_valid = req_valid[g]
  - snd_data = req_data[g]
  - snd_last = req_last[g]
  - req_ready[g] = snd_ready
  - all other req_ready bits are 0
- Transfer: snd_valid && snd_ready.
- Packet end: a transfer with snd_last=1. On packet end, go to IDLE and set ptr = (g+1) mod NREQ.
- Fairness: a requester cannot win twice in a row while another requester has req_valid high.
- Non-holders are never acknowledged. Their bytes must stay stable until they are granted.
- In IDLE: snd_valid=0, req_ready=0.
- Simultaneous events:
  - A request arriving in the same cycle as a packet end is evaluated in the following IDLE cycle.
  - A requester that drops req_valid mid-packet keeps the grant, subject to the timeout if that feature is compiled in.

## Timing
- Reset values:
  - state=IDLE, ptr=0, grant=0, busy=0, timeout_err=0
  - snd_valid=0, snd_data=0, snd_last=0, req_ready=0
- Arbitration latency: 1 cycle. A req_valid seen in IDLE at edge N gives busy=1 and data pass-through from cycle N+1.
- Packet gap: one IDLE bubble cycle between consecutive packets, including back-to-back packets from different requesters.
- Throughput inside a packet: one byte per cycle while snd_ready=1. The data path has zero added latency.
- Reset mid-packet:
  - Return to IDLE immediately on the next edge with all reset values.
  - The partial packet is abandoned; no snd_last is emitted.

## Configuration
- OUT_ARB_TIMEOUT_EN defined:
  - A 16-bit stall counter clears on every transfer and on entering GRANT.
  - It increments in each GRANT cycle where req_valid[g]=0.
  - When it reaches TIMEOUT:
    - force the FSM to IDLE;
    - set ptr=(g+1) mod NREQ;
    - set timeout_err=1, cleared only by reset.
  - Stalls caused by snd_ready=0 with req_valid[g]=1 never count.
- OUT_ARB_TIMEOUT_EN undefined:
  - No counter is built and timeout_err is tied to 0.
  - The grant is held indefinitely until packet end.

## Structure
- Shared package out_arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_GRANT);
  - the stall counter width constant ARB_STALL_W=16;
  - the device index constants DEV_NUM=0, DEV_CHR=1, DEV_DBG=2.
- Sub-module rr_pick:
  - combinational round-robin priority picker;
  - inputs: NREQ-bit request vector and start pointer;
  - outputs: found flag and winner index.
  - It is reusable for the bus arbiter.

## Test plan
- Single requester: req 0 sends " 42\n", 4 bytes, last on '\n', with snd_ready=1. The shim receives 0x20,0x34,0x32,0x0A on 4 consecutive cycles starting 1 cycle after req_valid rises; snd_last=1 only on 0x0A; busy falls after 0x0A.
- Contention: requesters 0, 1 and 3 each hold a 2-byte packet ready at reset release. Grant order is 0,1,3 with one bubble between packets and no interleaved bytes. A second packet from 0 is then served before 1 requests again.
- Backpressure: snd_ready toggles 1,0,1,0 during a 3-byte packet from requester 2. Each byte is accepted only on snd_ready=1, and req_ready[2] mirrors snd_ready. Requester 1 pending meanwhile gets req_ready[1]=0 throughout.
- Reset mid-packet: assert reset after byte 2 of 5 from requester 1. Next cycle shows all outputs at reset values with ptr=0; a following request from 1 restarts cleanly.
- Timeout (OUT_ARB_TIMEOUT_EN, TIMEOUT=8): requester 0 sends 1 non-last byte, then drops req_valid while requester 1 waits. After 8 stalled cycles the arbiter returns to IDLE, timeout_err=1, and requester 1 is granted on the next cycle.
- Without the macro, same stimulus: requester 0 keeps the grant for 100+ cycles and timeout_err stays 0.

Source files
------------

// File: rtl/out_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : out_arb_pkg
// Description : Shared types and constants for the host output-channel
//               arbiter: FSM state encoding, stall counter width and the
//               conventional requester slots of the output devices.
// Revision    : 1.0 - initial release
// ============================================================================
package out_arb_pkg;

   // Arbiter FSM states
   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   // Width of the stall counter used by the forced-release feature
   localparam int ARB_STALL_W = 16;

   // Requester slot assignments of the output devices
   localparam int DEV_NUM = 0;   // numeric display
   localparam int DEV_CHR = 1;   // character terminal
   localparam int DEV_DBG = 2;   // first debug tracer

endpackage : out_arb_pkg
`default_nettype wire

// File: rtl/out_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin priority picker. Returns the first
//               set bit of req found when scanning upward from start and
//               wrapping modulo NREQ.
// Ports       : req   in  NREQ  request vector
//               start in  IW    index scanned first (must be < NREQ)
//               found out 1     at least one request bit is set
//               idx   out IW    winning index (0 when found=0)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   start,
   output logic            found,
   output logic [IW-1:0]   idx
);

   // Scan from the farthest offset down to offset 0 so the candidate closest
   // to start is the last one written and therefore wins.
   always_comb begin
      int pos;
      pos   = 0;
      found = 1'b0;
      idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         pos = (int'(start) + k) % NREQ;
         if (req[pos]) begin
            found = 1'b1;
            idx   = IW'(pos);
         end
      end
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/out_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : out_port_arbiter
// Description : Shares the host serial output channel between NREQ byte
//               packet sources. Round-robin grant, held until the holder's
//               packet ends, one IDLE bubble between packets. While granted
//               the holder is passed straight through to the serial shim.
// Options     : OUT_ARB_TIMEOUT_EN - when defined, a holder that leaves its
//               req_valid low for TIMEOUT consecutive granted cycles loses
//               the grant and sets the sticky timeout_err flag.
// Ports       : clk, reset                  clock, synchronous active-high reset
//               req_valid/req_data/req_last requester byte ports (8 bits each)
//               req_ready                   per-requester acknowledge
//               snd_valid/snd_data/snd_last byte towards the serial shim
//               snd_ready                   shim accepts the byte
//               grant                       current or most recent holder
//               busy                        high while a grant is held
//               timeout_err                 sticky forced-release flag
// Revision    : 1.0 - initial release
// ============================================================================
module out_port_arbiter
   import out_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*8-1:0]        req_data,
   input  logic [NREQ-1:0]          req_last,
   output logic [NREQ-1:0]          req_ready,
   output logic                     snd_valid,
   output logic [7:0]               snd_data,
   output logic                     snd_last,
   input  logic                     snd_ready,
   output logic [$clog2(NREQ)-1:0]  grant,
   output logic                     busy,
   output logic                     timeout_err
);

   localparam int GW = $clog2(NREQ);

   arb_state_t      state, state_nxt;
   logic [GW-1:0]   ptr, ptr_nxt;
   logic [GW-1:0]   grant_nxt;
   logic            pick_found;
   logic [GW-1:0]   pick_idx;
   logic [GW-1:0]   grant_wrap;
   logic            xfer;
   logic            stall_hit;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (GW)
   ) u_rr_pick (
      .req   (req_valid),
      .start (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Pointer value that places the current holder last in the next search
   assign grant_wrap = (grant == GW'(NREQ - 1)) ? '0 : grant + GW'(1);

   assign xfer = snd_valid & snd_ready;
   assign busy = (state == ARB_GRANT);

   // Zero-latency pass-through from the holder; everything quiet in IDLE
   always_comb begin
      snd_valid = 1'b0;
      snd_data  = 8'h00;
      snd_last  = 1'b0;
      req_ready = '0;
      if (state == ARB_GRANT) begin
         snd_valid        = req_valid[grant];
         snd_data         = req_data[int'(grant) * 8 +: 8];
         snd_last         = req_last[grant];
         req_ready[grant] = snd_ready;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      grant_nxt = grant;
      case (state)
         ARB_IDLE: begin
            if (pick_found) begin
               state_nxt = ARB_GRANT;
               grant_nxt = pick_idx;
            end
         end
         ARB_GRANT: begin
            if ((xfer && snd_last) || stall_hit) begin
               state_nxt = ARB_IDLE;
               ptr_nxt   = grant_wrap;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ARB_IDLE;
         ptr   <= '0;
         grant <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         grant <= grant_nxt;
      end
   end

`ifdef OUT_ARB_TIMEOUT_EN
   logic [ARB_STALL_W-1:0] stall_cnt;

   // Only cycles where the holder itself has nothing to offer count; shim
   // backpressure with valid data never does.
   assign stall_hit = (state == ARB_GRANT) && !req_valid[grant] &&
                      ((stall_cnt + ARB_STALL_W'(1)) == ARB_STALL_W'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt   <= '0;
         timeout_err <= 1'b0;
      end else begin
         // Holding the counter at zero in IDLE clears it on entering GRANT
         if (state == ARB_IDLE || xfer) begin
            stall_cnt <= '0;
         end else if (!req_valid[grant]) begin
            stall_cnt <= stall_cnt + ARB_STALL_W'(1);
         end
         if (stall_hit) begin
            timeout_err <= 1'b1;
         end
      end
   end
`else
   assign stall_hit = 1'b0;
   // No forced release is built; the flag can only flag an out-of-range
   // TIMEOUT setting and is constant 0 for every legal configuration.
   assign timeout_err = (TIMEOUT < 1);
`endif

endmodule : out_port_arbiter
`default_nettype wire

// File: tb/tb_out_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_out_port_arbiter
// Description : Self-checking bench for out_port_arbiter. Byte sources feed
//               the requester ports; a cycle-level reference model predicts
//               every output and directed steps check the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_out_port_arbiter;
   import out_arb_pkg::*;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 8;
   localparam int QD      = 4096;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*8-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;
   logic              snd_valid;
   logic [7:0]        snd_data;
   logic              snd_last;
   logic              snd_ready;
   logic [1:0]        grant;
   logic              busy;
   logic              timeout_err;

   always #5 clk = ~clk;

   out_port_arbiter #(
      .NREQ    (NREQ),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .snd_valid   (snd_valid),
      .snd_data    (snd_data),
      .snd_last    (snd_last),
      .snd_ready   (snd_ready),
      .grant       (grant),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   // Byte sources: {last, data} per entry
   logic [8:0] sbuf [NREQ][QD];
   int         head [NREQ];
   int         tail [NREQ];

   // Reference model
   int m_hold;    // -1 when nobody holds the channel
   int m_ptr;
   int m_grant;
   int m_stall;
   bit m_err;

   // Transfers seen on the shim side
   logic [8:0] rx_byte [$];
   int         rx_cyc  [$];
   int         rx_src  [$];

   int cyc_n;
   int n_pass;
   int n_chk;

   logic [NREQ-1:0] obs_rr;
   logic            obs_sr;
   logic            obs_busy;
   logic [1:0]      obs_grant;
   logic            obs_terr;
   logic [31:0]     obs_all;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
   endtask

   task automatic push(input int r, input logic [7:0] b, input bit last);
      sbuf[r][tail[r]] = {last, b};
      tail[r]++;
   endtask

   task automatic push_pkt(input int r, input int len);
      for (int i = 0; i < len; i++) push(r, 8'($urandom), (i == len - 1));
   endtask

   task automatic rx_clear();
      rx_byte.delete();
      rx_cyc.delete();
      rx_src.delete();
   endtask

   // One clock cycle: drive sources, check outputs against the model,
   // advance the model and the sources, then step to the next falling edge.
   task automatic cyc();
      logic [NREQ-1:0] e_rdy;
      logic            e_sv;
      logic            e_sl;
      logic [7:0]      e_sd;
      logic [3:0]      e_ctrl;
      bit              hit;
      int              r;
      int              h;

      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]        = (head[i] < tail[i]);
         req_data[i*8 +: 8]  = req_valid[i] ? sbuf[i][head[i]][7:0] : 8'h00;
         req_last[i]         = req_valid[i] ? sbuf[i][head[i]][8] : 1'b0;
      end
      #1;

      e_rdy = '0;
      e_sv  = 1'b0;
      e_sl  = 1'b0;
      e_sd  = 8'h00;
      if (m_hold >= 0) begin
         e_sv          = req_valid[m_hold];
         e_sd          = req_data[m_hold*8 +: 8];
         e_sl          = req_last[m_hold];
         e_rdy[m_hold] = snd_ready;
      end
      e_ctrl = {(m_hold >= 0), 2'(m_grant), m_err};
      check("ctrl", {busy, grant, timeout_err}, e_ctrl);
      check("path", {snd_valid, snd_last, snd_data, req_ready}, {e_sv, e_sl, e_sd, e_rdy});

      obs_rr    = req_ready;
      obs_sr    = snd_ready;
      obs_busy  = busy;
      obs_grant = grant;
      obs_terr  = timeout_err;
      obs_all   = {snd_valid, snd_last, snd_data, req_ready, busy, grant, timeout_err};

      if (snd_valid && snd_ready) begin
         rx_byte.push_back({snd_last, snd_data});
         rx_cyc.push_back(cyc_n);
         rx_src.push_back(int'(grant));
      end

      // Sources release a byte whenever the model says it was taken
      for (int i = 0; i < NREQ; i++)
         if (e_rdy[i] && req_valid[i]) head[i]++;

      if (reset) begin
         m_hold  = -1;
         m_ptr   = 0;
         m_grant = 0;
         m_stall = 0;
         m_err   = 1'b0;
      end else if (m_hold < 0) begin
         hit = 1'b0;
         for (int k = 0; k < NREQ; k++) begin
            r = (m_ptr + k) % NREQ;
            if (!hit && req_valid[r]) begin
               hit     = 1'b1;
               m_hold  = r;
               m_grant = r;
               m_stall = 0;
            end
         end
      end else begin
         h = m_hold;
         if (req_valid[h] && snd_ready) begin
            m_stall = 0;
            if (req_last[h]) begin
               m_hold = -1;
               m_ptr  = (h + 1) % NREQ;
            end
         end else if (!req_valid[h]) begin
            m_stall++;
`ifdef OUT_ARB_TIMEOUT_EN
            if (m_stall == TIMEOUT) begin
               m_hold = -1;
               m_ptr  = (h + 1) % NREQ;
               m_err  = 1'b1;
            end
`endif
         end
      end

      cyc_n++;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [8:0] e1 [4];
      int         e2 [6];
      int         t0;
      int         guard;
      int         left;

      n_pass = 0;
      n_chk  = 0;
      cyc_n  = 0;
      for (int i = 0; i < NREQ; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      reset     = 1'b1;
      snd_ready = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      @(posedge clk);
      @(negedge clk);
      m_hold  = -1;
      m_ptr   = 0;
      m_grant = 0;
      m_stall = 0;
      m_err   = 1'b0;

      // ---- reset state ---------------------------------------------------
      cyc();
      cyc();
      check("reset_outputs", obs_all, 32'h0);

      // ---- single requester " 42\n" --------------------------------------
      reset     = 1'b0;
      snd_ready = 1'b1;
      rx_clear();
      push(DEV_NUM, 8'h20, 1'b0);
      push(DEV_NUM, 8'h34, 1'b0);
      push(DEV_NUM, 8'h32, 1'b0);
      push(DEV_NUM, 8'h0A, 1'b1);
      t0 = cyc_n;
      repeat (7) cyc();
      e1 = '{9'h020, 9'h034, 9'h032, 9'h10A};
      check("single_count", rx_byte.size(), 4);
      for (int i = 0; i < 4 && i < rx_byte.size(); i++) begin
         check("single_byte", rx_byte[i], e1[i]);
         check("single_cycle", rx_cyc[i], t0 + 1 + i);
      end
      check("single_idle", obs_busy, 1'b0);

      // ---- contention between 0, 1 and 3 ---------------------------------
      reset = 1'b1;
      push_pkt(0, 2);
      push_pkt(1, 2);
      push_pkt(3, 2);
      cyc();
      reset = 1'b0;
      rx_clear();
      repeat (12) cyc();
      e2 = '{0, 0, 1, 1, 3, 3};
      check("cont_count", rx_byte.size(), 6);
      for (int i = 0; i < 6 && i < rx_src.size(); i++)
         check("cont_order", rx_src[i], e2[i]);
      if (rx_cyc.size() >= 6) begin
         check("cont_bubble01", rx_cyc[2] - rx_cyc[1], 2);
         check("cont_bubble13", rx_cyc[4] - rx_cyc[3], 2);
      end
      rx_clear();
      push_pkt(0, 2);
      cyc();
      push_pkt(1, 2);
      repeat (8) cyc();
      check("cont_again_cnt", rx_src.size(), 4);
      if (rx_src.size() >= 3) begin
         check("cont_again0", rx_src[0], 0);
         check("cont_again1", rx_src[2], 1);
      end

      // ---- backpressure on requester 2, requester 1 pending --------------
      snd_ready = 1'b1;
      rx_clear();
      push_pkt(2, 3);
      cyc();
      push_pkt(1, 1);
      for (int i = 0; i < 5; i++) begin
         snd_ready = (i % 2 == 0);
         cyc();
         check("bp_ready2", obs_rr[2], obs_sr);
         check("bp_ready1", obs_rr[1], 1'b0);
      end
      snd_ready = 1'b1;
      repeat (4) cyc();
      check("bp_count", rx_byte.size(), 4);
      if (rx_cyc.size() >= 4) begin
         check("bp_gap", rx_cyc[2] - rx_cyc[0], 4);
         check("bp_last2", rx_byte[2][8], 1'b1);
         check("bp_then1", rx_src[3], 1);
      end

      // ---- reset in the middle of a 5-byte packet from requester 1 -------
      rx_clear();
      push_pkt(1, 5);
      repeat (3) cyc();
      check("rst_partial", rx_byte.size(), 2);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      head[1] = tail[1];
      cyc();
      check("rst_outputs", obs_all, 32'h0);
      rx_clear();
      push_pkt(1, 2);
      push_pkt(3, 2);
      repeat (8) cyc();
      check("rst_restart_cnt", rx_src.size(), 4);
      if (rx_src.size() >= 2) begin
         check("rst_ptr0", rx_src[0], 1);
         check("rst_restart_last", rx_byte[1][8], 1'b1);
      end

      // ---- holder drops req_valid mid-packet while requester 1 waits -----
      rx_clear();
      push(0, 8'h41, 1'b0);
      push_pkt(1, 2);
      cyc();
      cyc();
`ifdef OUT_ARB_TIMEOUT_EN
      repeat (TIMEOUT) cyc();
      check("to_busy_last", obs_busy, 1'b1);
      cyc();
      check("to_idle", obs_busy, 1'b0);
      check("to_err", obs_terr, 1'b1);
      cyc();
      check("to_regrant", {obs_busy, obs_grant}, 3'b101);
      push(0, 8'h0A, 1'b1);
      repeat (8) cyc();
`else
      repeat (105) cyc();
      check("hold_busy", obs_busy, 1'b1);
      check("hold_grant", obs_grant, 2'd0);
      check("hold_err", obs_terr, 1'b0);
      push(0, 8'h0A, 1'b1);
      repeat (8) cyc();
      check("hold_count", rx_src.size(), 4);
      if (rx_src.size() >= 3) begin
         check("hold_end0", rx_byte[1], 9'h10A);
         check("hold_then1", rx_src[2], 1);
      end
`endif

      // ---- randomized traffic against the model --------------------------
      repeat (300) begin
         for (int r = 0; r < NREQ; r++)
            if (head[r] == tail[r] && $urandom_range(3) == 0)
               push_pkt(r, int'($urandom_range(4, 1)));
         snd_ready = ($urandom_range(3) != 0);
         cyc();
      end
      snd_ready = 1'b1;
      guard = 0;
      left  = 1;
      while (left != 0 && guard < 300) begin
         cyc();
         guard++;
         left = obs_busy ? 1 : 0;
         for (int r = 0; r < NREQ; r++) left += tail[r] - head[r];
      end
      check("drain_left", left, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_out_port_arbiter
`default_nettype wire
